instr_fetch: RTL and testbench

Instruction fetch stage for the 32-bit pipelined CPU; the producer side of the decode interface. Drives the synchronous instruction memory, tracks the fetch PC, and presents `instr`, `PC_out`, and `next_PC` to decode. Accepts `stall`, branch/jump redirects (`branch_taken`/`branch_addr`), and `hlt` back from decode. Holds in a halted state until `resume`.

---
 rtl/instr_fetch.sv | 85 ++++++++
 tb/tb_instr_fetch.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC tracking, redirect, stall and halt control
module instr_fetch #(
  parameter int unsigned    PC_W      = 22,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]    NOP_INSTR = 32'h7800_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_addr,
  input  logic            hlt,
  input  logic            resume,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_en,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [PC_W-1:0] PC_out,
  output logic [PC_W-1:0] next_PC,
  output logic            halted
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] data_pc_q, data_pc_d;
  logic            valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      data_pc_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      data_pc_q  <= data_pc_d;
      valid_q    <= valid_d;
    end
  end

  // Priority: stall > halt > redirect > sequential step; HALTED leaves only on resume.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    data_pc_d  = data_pc_q;
    valid_d    = valid_q;
    if (!stall) begin
      if (state_q == RUN) begin
        if (hlt) begin
          state_d = HALTED;
          valid_d = 1'b0;
        end else if (branch_taken) begin
          fetch_pc_d = branch_addr;
          valid_d    = 1'b0;
        end else begin
          data_pc_d  = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_W'(1);
          valid_d    = 1'b1;
        end
      end else if (resume) begin
        state_d    = RUN;
        data_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + PC_W'(1);
        valid_d    = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    imem_addr   = fetch_pc_q;
    imem_en     = ~stall & ((state_q == RUN) | resume);
    instr_valid = valid_q;
    instr       = valid_q ? imem_rdata : NOP_INSTR;
    PC_out      = data_pc_q;
    next_PC     = data_pc_q + PC_W'(1);
    halted      = (state_q == HALTED);
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed scoreboard bench for instr_fetch
module tb_instr_fetch;
  localparam int unsigned    PC_W      = 22;
  localparam logic [PC_W-1:0] RESET_PC  = 22'h10;
  localparam logic [31:0]    NOP_INSTR = 32'h7800_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            stall = 1'b0;
  logic            branch_taken = 1'b0;
  logic [PC_W-1:0] branch_addr = '0;
  logic            hlt = 1'b0;
  logic            resume = 1'b0;
  logic [PC_W-1:0] imem_addr;
  logic            imem_en;
  logic [31:0]     imem_rdata;
  logic [31:0]     instr;
  logic            instr_valid;
  logic [PC_W-1:0] PC_out;
  logic [PC_W-1:0] next_PC;
  logic            halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic            halted;
  } exp_t;
  exp_t sb_q[$];

  instr_fetch #(.PC_W(PC_W), .RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .hlt(hlt), .resume(resume), .imem_addr(imem_addr),
    .imem_en(imem_en), .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .PC_out(PC_out), .next_PC(next_PC), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous memory with mem[i] = i
  always_ff @(posedge clk) if (imem_en) imem_rdata <= 32'(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " imem_addr"}, 32'(imem_addr), 32'(RESET_PC));
    chk({tag, " instr"}, instr, NOP_INSTR);
    chk({tag, " instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, " PC_out"}, 32'(PC_out), 32'd0);
    chk({tag, " next_PC"}, 32'(next_PC), 32'd1);
    chk({tag, " halted"}, 32'(halted), 32'd0);
    chk({tag, " imem_en"}, 32'(imem_en), 32'd1);
  endtask

  // Push the expectation for the coming edge, clock it, then pop and compare at the negedge.
  task automatic step(input logic v, input logic [PC_W-1:0] pc, input logic h);
    exp_t e;
    exp_t got;
    logic [PC_W-1:0] npc;
    e.valid = v; e.pc = pc; e.halted = h;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else begin
      got = sb_q.pop_front();
      npc = got.pc + PC_W'(1);
      chk("instr_valid", 32'(instr_valid), 32'(got.valid));
      chk("instr", instr, got.valid ? 32'(got.pc) : NOP_INSTR);
      chk("PC_out", 32'(PC_out), 32'(got.pc));
      chk("next_PC", 32'(next_PC), 32'(npc));
      chk("halted", 32'(halted), 32'(got.halted));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    // Sequential fetch from RESET_PC
    step(1, 22'h10, 0);
    step(1, 22'h11, 0);
    step(1, 22'h12, 0);
    step(1, 22'h13, 0);
    step(1, 22'h14, 0);

    // Redirect: one bubble then target
    branch_taken = 1'b1; branch_addr = 22'h200;
    step(0, 22'h14, 0);
    branch_taken = 1'b0;
    step(1, 22'h200, 0);
    step(1, 22'h201, 0);

    branch_taken = 1'b1; branch_addr = 22'h20;
    step(0, 22'h201, 0);
    branch_taken = 1'b0;
    step(1, 22'h20, 0);

    // Stall with a redirect pulse inside it
    stall = 1'b1;
    #1 chk("stall imem_en", 32'(imem_en), 32'd0);
    step(1, 22'h20, 0);
    branch_taken = 1'b1; branch_addr = 22'h155;
    step(1, 22'h20, 0);
    branch_taken = 1'b0;
    step(1, 22'h20, 0);
    chk("stall imem_addr", 32'(imem_addr), 32'h21);
    stall = 1'b0;
    step(1, 22'h21, 0);

    branch_taken = 1'b1; branch_addr = 22'h30;
    step(0, 22'h21, 0);
    branch_taken = 1'b0;
    step(1, 22'h30, 0);

    // Halt together with a redirect: halt wins
    hlt = 1'b1; branch_taken = 1'b1; branch_addr = 22'h100;
    step(0, 22'h30, 1);
    hlt = 1'b0; branch_taken = 1'b0;
    chk("halted imem_en", 32'(imem_en), 32'd0);
    step(0, 22'h30, 1);
    branch_taken = 1'b1; branch_addr = 22'h100;
    step(0, 22'h30, 1);
    branch_taken = 1'b0;
    step(0, 22'h30, 1);
    step(0, 22'h30, 1);
    resume = 1'b1;
    #1 chk("resume imem_en", 32'(imem_en), 32'd1);
    step(1, 22'h31, 0);
    resume = 1'b0;
    step(1, 22'h32, 0);
    resume = 1'b1;
    step(1, 22'h33, 0);
    resume = 1'b0;

    // Wrap-around at the top of the address space
    branch_taken = 1'b1; branch_addr = 22'h3FFFFE;
    step(0, 22'h33, 0);
    branch_taken = 1'b0;
    step(1, 22'h3FFFFE, 0);
    step(1, 22'h3FFFFF, 0);
    step(1, 22'h000000, 0);

    // Async reset while HALTED
    hlt = 1'b1;
    step(0, 22'h000000, 1);
    hlt = 1'b0;
    rst_n = 1'b0;
    #1 chk_reset("async halted");
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 22'h10, 0);

    // Async reset right after a redirect
    branch_taken = 1'b1; branch_addr = 22'h2AA;
    step(0, 22'h10, 0);
    branch_taken = 1'b0;
    rst_n = 1'b0;
    #1 chk_reset("async redirect");
    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
